// File: rtl/accel_bus_switch_pkg.sv
// Shared ids, widths and decode kinds for the
// accelerator bus switch.
package accel_bus_pkg;

  localparam int ACCEL_DATA_WIDTH = 16;
  localparam int ACCEL_ID_EVENTS  = 0;

  typedef enum logic [3:0] {
    ID_EVENTS   = 4'd0,
    ID_LINE     = 4'd1,
    ID_FILL     = 4'd2,
    ID_SYMBOL   = 4'd3,
    ID_KEYBOARD = 4'd4,
    ID_ALU      = 4'd5,
    ID_SM       = 4'd6,
    ID_FIFO     = 4'd7
  } accel_id_e;

  typedef enum logic [1:0] {
    SEL_EVENTS,
    SEL_CHANNEL,
    SEL_NONE
  } sel_kind_e;

endpackage

// File: rtl/accel_bus_switch_if.sv
// CPU accelerator port plus the fanned-out
// channel side, bundled for the switch.
interface accel_bus_switch_if
  import accel_bus_pkg::*;
#(
  parameter int NUM_CH     = 7,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = ACCEL_DATA_WIDTH
);
  logic [ID_WIDTH-1:0]          accel_id;
  logic                         cpu_read_enable;
  logic                         cpu_write_enable;
  logic [DATA_WIDTH-1:0]        cpu_write_data;
  logic                         cpu_can_read;
  logic                         cpu_can_write;
  logic [DATA_WIDTH-1:0]        cpu_read_data;
  logic [NUM_CH-1:0]            ch_can_read;
  logic [NUM_CH-1:0]            ch_can_write;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_read_data;
  logic [NUM_CH-1:0]            ch_read_enable;
  logic [NUM_CH-1:0]            ch_write_enable;
  logic [DATA_WIDTH-1:0]        ch_write_data;

  modport slave (
    input  accel_id, cpu_read_enable,
    input  cpu_write_enable, cpu_write_data,
    input  ch_can_read, ch_can_write,
    input  ch_read_data,
    output cpu_can_read, cpu_can_write,
    output cpu_read_data,
    output ch_read_enable, ch_write_enable,
    output ch_write_data
  );

  modport master (
    output accel_id, cpu_read_enable,
    output cpu_write_enable, cpu_write_data,
    output ch_can_read, ch_can_write,
    output ch_read_data,
    input  cpu_can_read, cpu_can_write,
    input  cpu_read_data,
    input  ch_read_enable, ch_write_enable,
    input  ch_write_data
  );
endinterface

// File: rtl/accel_stall_watchdog.sv
// Counts consecutive stalled cycles on one id and
// latches a sticky error with the first culprit.
module accel_stall_watchdog
  import accel_bus_pkg::*;
#(
  parameter int ID_WIDTH    = 4,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_WIDTH-1:0] accel_id,
  input  logic                stalled,
  input  logic                stall_clear,
  output logic                stall_error,
  output logic [ID_WIDTH-1:0] stall_id
);
  localparam int CW = $clog2(STALL_LIMIT + 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] prev_id_q;
  logic                err_q, err_d;
  logic [ID_WIDTH-1:0] id_q, id_d;

  always_comb begin
    cnt_d = '0;
    err_d = err_q;
    id_d  = id_q;
    if (stalled && (accel_id == prev_id_q)) begin
      if (cnt_q == CW'(STALL_LIMIT)) cnt_d = cnt_q;
      else                           cnt_d = cnt_q + 1'b1;
    end
    // clear beats a coinciding trip
    if (stall_clear) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else if (cnt_d == CW'(STALL_LIMIT) && !err_q) begin
      err_d = 1'b1;
      id_d  = accel_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      prev_id_q <= '0;
      err_q     <= 1'b0;
      id_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      prev_id_q <= accel_id;
      err_q     <= err_d;
      id_q      <= id_d;
    end
  end

  assign stall_error = err_q;
  assign stall_id    = id_q;
endmodule

// File: rtl/accel_bus_switch.sv
// Decodes accel_id, steers strobes to channels, merges
// readiness/data back, and hosts the id-0 event register.
module accel_bus_switch
  import accel_bus_pkg::*;
#(
  parameter int NUM_CH        = 7,
  parameter int ID_WIDTH      = 4,
  parameter int DATA_WIDTH    = ACCEL_DATA_WIDTH,
  parameter int NUM_EVENTS    = 1,
  parameter int INIT_EVENTS   = 1,
  parameter int STALL_LIMIT   = 1024,
  parameter int WATCHDOG_MASK = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  accel_bus_switch_if.slave     bus,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  stall_clear,
  output logic                  stall_error,
  output logic [ID_WIDTH-1:0]   stall_id
);
  logic [NUM_CH-1:0]     sel;
  sel_kind_e             kind;
  logic                  ch_rd_rdy, ch_wr_rdy;
  logic [DATA_WIDTH-1:0] ch_rdata;
  logic [NUM_EVENTS-1:0] pending_q, pending_d;
  logic                  ev_rd, ev_wr, stalled;

  always_comb begin
    sel      = '0;
    ch_rdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel[k]   = (bus.accel_id == ID_WIDTH'(k + 1));
      ch_rdata = ch_rdata
        | ({DATA_WIDTH{sel[k]}}
        & bus.ch_read_data[k*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign kind =
    (bus.accel_id == ID_WIDTH'(ACCEL_ID_EVENTS)) ? SEL_EVENTS :
    (|sel)                                       ? SEL_CHANNEL :
                                                   SEL_NONE;

  assign ch_rd_rdy = |(sel & bus.ch_can_read);
  assign ch_wr_rdy = |(sel & bus.ch_can_write);
  assign bus.ch_write_data = bus.cpu_write_data;

  always_comb begin
    bus.cpu_can_read    = 1'b0;
    bus.cpu_can_write   = 1'b0;
    bus.cpu_read_data   = '0;
    bus.ch_read_enable  = '0;
    bus.ch_write_enable = '0;
    unique case (kind)
      SEL_EVENTS: begin
        bus.cpu_can_read  = |pending_q;
        bus.cpu_can_write = 1'b1;
        bus.cpu_read_data = DATA_WIDTH'(pending_q);
      end
      SEL_CHANNEL: begin
        bus.cpu_can_read    = ch_rd_rdy;
        bus.cpu_can_write   = ch_wr_rdy;
        bus.cpu_read_data   = ch_rdata;
        bus.ch_read_enable  = sel & {NUM_CH{bus.cpu_read_enable}};
        bus.ch_write_enable = sel & {NUM_CH{bus.cpu_write_enable}};
      end
      default: ;
    endcase
  end

  assign ev_rd = (kind == SEL_EVENTS) && bus.cpu_read_enable;
  assign ev_wr = (kind == SEL_EVENTS) && bus.cpu_write_enable;

  // a read drains every set bit; new events always survive
  always_comb begin
    pending_d = pending_q;
    if (ev_rd)      pending_d = '0;
    else if (ev_wr) pending_d = pending_q
                      & ~bus.cpu_write_data[NUM_EVENTS-1:0];
    pending_d = pending_d | event_in;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= NUM_EVENTS'(INIT_EVENTS);
    else     pending_q <= pending_d;
  end

  assign stalled = (kind == SEL_CHANNEL)
    && !(|(sel & NUM_CH'(WATCHDOG_MASK)))
    && !ch_rd_rdy && !ch_wr_rdy;

  accel_stall_watchdog #(
    .ID_WIDTH    (ID_WIDTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_wdog (
    .clk         (clk),
    .rst         (rst),
    .accel_id    (bus.accel_id),
    .stalled     (stalled),
    .stall_clear (stall_clear),
    .stall_error (stall_error),
    .stall_id    (stall_id)
  );
endmodule

// File: tb/tb_accel_bus_switch.sv
// Randomised scoreboard bench for accel_bus_switch
// against a per-cycle behavioural model.
module tb_accel_bus_switch;
  import accel_bus_pkg::*;

  localparam int NCH  = 7;
  localparam int IDW  = 4;
  localparam int DW   = 16;
  localparam int NEV  = 3;
  localparam int INIT = 1;
  localparam int LIM  = 8;
  localparam int MASK = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [NEV-1:0] event_in;
  logic           stall_clear;
  logic           stall_error;
  logic [IDW-1:0] stall_id;

  accel_bus_switch_if #(
    .NUM_CH(NCH), .ID_WIDTH(IDW), .DATA_WIDTH(DW)
  ) bus ();

  accel_bus_switch #(
    .NUM_CH(NCH), .ID_WIDTH(IDW), .DATA_WIDTH(DW),
    .NUM_EVENTS(NEV), .INIT_EVENTS(INIT),
    .STALL_LIMIT(LIM), .WATCHDOG_MASK(MASK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .event_in    (event_in),
    .stall_clear (stall_clear),
    .stall_error (stall_error),
    .stall_id    (stall_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic [IDW-1:0]    id;
    logic              re, we;
    logic [DW-1:0]     wd;
    logic [NCH-1:0]    ccr, ccw;
    logic [NCH*DW-1:0] crd;
    logic [NEV-1:0]    ev;
    logic              clr;
  } stim_t;

  typedef struct {
    logic           cr, cw;
    logic [DW-1:0]  rd;
    logic [NCH-1:0] re, we;
    logic [DW-1:0]  wd;
    logic           err;
    logic [IDW-1:0] sid;
  } exp_t;

  exp_t  sbq[$];
  exp_t  mon_e;
  stim_t cur;
  int    checks = 0;
  int    failures = 0;

  bit [NEV-1:0] m_pend;
  int m_cnt, m_sid, m_prev;
  bit m_err;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      chk("can_read", 32'(bus.cpu_can_read), 32'(mon_e.cr));
      chk("can_write", 32'(bus.cpu_can_write), 32'(mon_e.cw));
      chk("read_data", 32'(bus.cpu_read_data), 32'(mon_e.rd));
      chk("ch_re", 32'(bus.ch_read_enable), 32'(mon_e.re));
      chk("ch_we", 32'(bus.ch_write_enable), 32'(mon_e.we));
      chk("ch_wd", 32'(bus.ch_write_data), 32'(mon_e.wd));
      chk("stall_err", 32'(stall_error), 32'(mon_e.err));
      chk("stall_id", 32'(stall_id), 32'(mon_e.sid));
    end
  end

  // state update for the edge that consumed `cur`
  task automatic apply_edge();
    int  idv;
    bit  st;
    if (cur.rst) begin
      m_pend = NEV'(INIT);
      m_cnt = 0; m_err = 0; m_sid = 0; m_prev = 0;
      return;
    end
    for (int i = 0; i < NEV; i++) begin
      if (cur.ev[i]) m_pend[i] = 1'b1;
      else if (cur.id == 0 && cur.re) m_pend[i] = 1'b0;
      else if (cur.id == 0 && cur.we && cur.wd[i])
        m_pend[i] = 1'b0;
    end
    idv = int'(cur.id);
    st = 0;
    if (idv >= 1 && idv <= NCH && idv == m_prev)
      if (((MASK >> (idv - 1)) & 1) == 0)
        if (!cur.ccr[idv-1] && !cur.ccw[idv-1]) st = 1;
    if (st) m_cnt = (m_cnt < LIM) ? m_cnt + 1 : LIM;
    else    m_cnt = 0;
    if (cur.clr) begin
      m_err = 0; m_cnt = 0;
    end else if (m_cnt == LIM && !m_err) begin
      m_err = 1; m_sid = idv;
    end
    m_prev = idv;
  endtask

  function automatic exp_t expect_of();
    exp_t e;
    int   idv, k;
    e = '{default: '0};
    idv = int'(cur.id);
    e.wd = cur.wd;
    e.err = m_err;
    e.sid = IDW'(m_sid);
    if (idv == 0) begin
      e.cr = |m_pend;
      e.cw = 1'b1;
      e.rd = DW'(m_pend);
    end else if (idv <= NCH) begin
      k = idv - 1;
      e.cr = cur.ccr[k];
      e.cw = cur.ccw[k];
      e.rd = cur.crd[k*DW +: DW];
      e.re[k] = cur.re;
      e.we[k] = cur.we;
    end
    return e;
  endfunction

  task automatic drive();
    rst                  = cur.rst;
    bus.accel_id         = cur.id;
    bus.cpu_read_enable  = cur.re;
    bus.cpu_write_enable = cur.we;
    bus.cpu_write_data   = cur.wd;
    bus.ch_can_read      = cur.ccr;
    bus.ch_can_write     = cur.ccw;
    bus.ch_read_data     = cur.crd;
    event_in             = cur.ev;
    stall_clear          = cur.clr;
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    apply_edge();
    cur = s;
    drive();
    sbq.push_back(expect_of());
  endtask

  function automatic stim_t idle(input int id);
    stim_t s;
    s = '{default: '0};
    s.id = IDW'(id);
    for (int k = 0; k < NCH; k++)
      s.crd[k*DW +: DW] = DW'(16'h1111 * (k + 1));
    return s;
  endfunction

  task automatic hold(input stim_t s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t s;
    cur = idle(0);
    cur.rst = 1'b1;
    drive();
    s = cur;
    hold(s, 2);
    hold(idle(0), 2);
    s = idle(0); s.re = 1'b1;
    step(s);
    hold(idle(0), 2);
    s = idle(0); s.ev = 3'b011;
    step(s);
    step(idle(0));
    s = idle(0); s.re = 1'b1; s.ev = 3'b010;
    step(s);
    step(idle(0));
    s = idle(0); s.re = 1'b1;
    step(s);
    s = idle(0); s.ev = 3'b101;
    step(s);
    s = idle(0); s.we = 1'b1; s.wd = 16'h0004;
    s.ev = 3'b100;
    step(s);
    hold(idle(0), 2);
    s = idle(0); s.id = ID_ALU; s.re = 1'b1;
    s.ccr = 7'b0010000; s.crd[4*DW +: DW] = 16'hBEEF;
    step(s);
    s = idle(12); s.ccr = '1; s.ccw = '1;
    s.re = 1'b1; s.we = 1'b1; s.wd = 16'hA5A5;
    hold(s, 2);
    hold(idle(3), 12);
    hold(idle(1), 12);
    s = idle(1); s.clr = 1'b1;
    step(s);
    hold(idle(0), 2);
    hold(idle(7), 12);
    hold(idle(2), 12);
    hold(idle(0), 2);

    for (int c = 0; c < 1500; c++) begin
      s = idle(0);
      if ($urandom_range(0, 9) < 8) s.id = cur.id;
      else s.id = IDW'($urandom_range(0, 15));
      if (((c / 40) % 2) == 1) begin
        s.ccr = NCH'($urandom & $urandom & $urandom);
        s.ccw = NCH'($urandom & $urandom & $urandom);
      end else begin
        s.ccr = NCH'($urandom);
        s.ccw = NCH'($urandom);
      end
      s.re = ($urandom_range(0, 2) == 0);
      s.we = ($urandom_range(0, 2) == 0);
      s.wd = DW'($urandom);
      for (int k = 0; k < NCH; k++)
        s.crd[k*DW +: DW] = DW'($urandom);
      s.ev  = NEV'($urandom & $urandom & $urandom);
      s.clr = ($urandom_range(0, 29) == 0);
      s.rst = ($urandom_range(0, 199) == 0);
      step(s);
    end
    hold(idle(0), 2);

    for (int w = 0; w < 10 && sbq.size() > 0; w++)
      @(negedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d exp=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
